// File: rtl/int_level_sched_if.sv
// Microcode/interrupt bus of the program-level scheduler.
// The slave side is the scheduler; the master side is the microprogram and interrupt sources.
interface int_level_sched_if #(
  parameter int NLEV = 16
);
  localparam int LW = $clog2(NLEV);

  logic [NLEV-1:0] WDATA;
  logic            LD_PID;
  logic            LD_PIE;
  logic [NLEV-1:0] PID_SET;
  logic            LVEXIT;
  logic            ION;
  logic            LVACK;
  logic [LW-1:0]   PIL;
  logic [NLEV-1:0] PID;
  logic [NLEV-1:0] PIE;
  logic            LVREQ;
  logic [LW-1:0]   NEWLVL;
  logic            BUSY;

  modport master (
    output WDATA, LD_PID, LD_PIE, PID_SET, LVEXIT, ION, LVACK,
    input  PIL, PID, PIE, LVREQ, NEWLVL, BUSY
  );

  modport slave (
    input  WDATA, LD_PID, LD_PIE, PID_SET, LVEXIT, ION, LVACK,
    output PIL, PID, PIE, LVREQ, NEWLVL, BUSY
  );
endinterface

// File: rtl/int_level_sched.sv
// Priority-interrupt level scheduler: PID/PIE/PIL registers, highest-level pick, req/ack switch.
// Request rises one edge after PID/PIE settle; holds LVREQ/NEWLVL until LVACK or ION drops.
module int_level_sched #(
  parameter int NLEV   = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             MCL_n,
  int_level_sched_if.slave bus
);
  localparam int LW = $clog2(NLEV);

  typedef enum logic [1:0] {IDLE, REQ, SWITCH, SETL} state_t;

  state_t          state_q, state_d;
  logic [NLEV-1:0] pid_q, pid_d;
  logic [NLEV-1:0] pie_q, pie_d;
  logic [LW-1:0]   pil_q, pil_d;
  logic [LW-1:0]   newlvl_q, newlvl_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [NLEV-1:0] act;
  logic [LW-1:0]   hp;

  // Set strobes are OR'd last so a hardware interrupt is never lost to a load or exit.
  always_comb begin
    pid_d = bus.LD_PID ? bus.WDATA : pid_q;
    if (bus.LVEXIT) pid_d[pil_q] = 1'b0;
    pid_d = pid_d | bus.PID_SET;
    pie_d = bus.LD_PIE ? bus.WDATA : pie_q;
  end

  always_comb begin
    act    = pid_q & pie_q;
    act[0] = 1'b1;
    hp     = '0;
    for (int i = 0; i < NLEV; i++) begin
      if (act[i]) hp = LW'(i);
    end
  end

  always_ff @(posedge clk or negedge MCL_n) begin
    if (!MCL_n) begin
      state_q  <= IDLE;
      pid_q    <= '0;
      pie_q    <= '0;
      pil_q    <= '0;
      newlvl_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pid_q    <= pid_d;
      pie_q    <= pie_d;
      pil_q    <= pil_d;
      newlvl_q <= newlvl_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pil_d    = pil_q;
    newlvl_d = newlvl_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ION && hp != pil_q) begin
          state_d  = REQ;
          newlvl_d = hp;
        end
      end
      REQ: begin
        // Dropping ION withdraws the request even if the ack arrives on the same edge.
        if (!bus.ION) begin
          state_d = IDLE;
        end else if (bus.LVACK) begin
          state_d = SWITCH;
          pil_d   = newlvl_q;
        end
      end
      SWITCH: begin
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? SETL : IDLE;
      end
      SETL: begin
        cnt_d = cnt_q + 2'd1;
        if (int'(cnt_q) + 1 >= SETTLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.PIL    = pil_q;
    bus.PID    = pid_q;
    bus.PIE    = pie_q;
    bus.NEWLVL = newlvl_q;
    bus.LVREQ  = (state_q == REQ);
    bus.BUSY   = (state_q == SWITCH) || (state_q == SETL);
  end
endmodule

// File: tb/tb_int_level_sched.sv
// Directed bench for int_level_sched: hand-computed expectations, sampled 1 time unit after each rising edge.
module tb_int_level_sched;
  logic clk;
  logic MCL_n;
  int   checks;
  int   errors;

  int_level_sched_if #(.NLEV(16)) bus ();

  int_level_sched #(.NLEV(16), .SETTLE(1)) dut (
    .clk   (clk),
    .MCL_n (MCL_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.WDATA   = '0;
    bus.LD_PID  = 1'b0;
    bus.LD_PIE  = 1'b0;
    bus.PID_SET = '0;
    bus.LVEXIT  = 1'b0;
    bus.ION     = 1'b0;
    bus.LVACK   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    MCL_n = 1'b0;
    tick();
    MCL_n = 1'b1;
    tick();
  endtask

  task automatic load_pie(input logic [15:0] v);
    bus.WDATA  = v;
    bus.LD_PIE = 1'b1;
    tick();
    bus.LD_PIE = 1'b0;
    bus.WDATA  = '0;
  endtask

  task automatic pulse_set(input logic [15:0] v);
    bus.PID_SET = v;
    tick();
    bus.PID_SET = '0;
  endtask

  task automatic ack();
    bus.LVACK = 1'b1;
    tick();
    bus.LVACK = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    MCL_n = 1'b0;
    #3;
    chk("rst_pil", 32'(bus.PIL), 0);
    chk("rst_pid", 32'(bus.PID), 0);
    chk("rst_pie", 32'(bus.PIE), 0);
    chk("rst_lvreq", 32'(bus.LVREQ), 0);
    chk("rst_newlvl", 32'(bus.NEWLVL), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    tick();
    MCL_n = 1'b1;
    tick();

    // Single interrupt at level 10
    load_pie(16'hFFFF);
    chk("pie_ffff", 32'(bus.PIE), 32'hFFFF);
    bus.ION = 1'b1;
    tick();
    chk("idle_noreq", 32'(bus.LVREQ), 0);
    pulse_set(16'h0400);
    chk("pid_0400", 32'(bus.PID), 32'h0400);
    chk("lat_edge1", 32'(bus.LVREQ), 0);
    tick();
    chk("lvreq_10", 32'(bus.LVREQ), 1);
    chk("newlvl_10", 32'(bus.NEWLVL), 10);
    ack();
    chk("pil_10", 32'(bus.PIL), 10);
    chk("ack_lvreq0", 32'(bus.LVREQ), 0);
    chk("switch_busy", 32'(bus.BUSY), 1);
    tick();
    chk("settle_busy", 32'(bus.BUSY), 1);
    tick();
    chk("idle_busy0", 32'(bus.BUSY), 0);
    chk("idle_hp_eq", 32'(bus.LVREQ), 0);
    ack();
    chk("stray_ack_pil", 32'(bus.PIL), 10);
    chk("stray_ack_busy", 32'(bus.BUSY), 0);

    // Two sets at once, then exit down
    pulse_set(16'h2800);
    tick();
    chk("lvreq_13", 32'(bus.LVREQ), 1);
    chk("newlvl_13", 32'(bus.NEWLVL), 13);
    ack();
    chk("pil_13", 32'(bus.PIL), 13);
    tick();
    tick();
    chk("idle_at_13", 32'(bus.LVREQ), 0);
    bus.LVEXIT = 1'b1;
    tick();
    bus.LVEXIT = 1'b0;
    chk("exit_pid", 32'(bus.PID), 32'h0C00);
    tick();
    chk("lvreq_11", 32'(bus.LVREQ), 1);
    chk("newlvl_11", 32'(bus.NEWLVL), 11);
    ack();
    chk("pil_11", 32'(bus.PIL), 11);
    tick();
    tick();

    // Masked interrupt, then enabled by PIE load
    do_reset();
    load_pie(16'h0001);
    bus.ION = 1'b1;
    pulse_set(16'h8000);
    chk("masked_pid", 32'(bus.PID), 32'h8000);
    tick();
    tick();
    chk("masked_noreq", 32'(bus.LVREQ), 0);
    chk("masked_pil", 32'(bus.PIL), 0);
    load_pie(16'h8000);
    tick();
    chk("unmask_req", 32'(bus.LVREQ), 1);
    chk("unmask_lvl", 32'(bus.NEWLVL), 15);

    // ION drop while waiting for ack
    bus.ION = 1'b0;
    tick();
    chk("ion_off_req", 32'(bus.LVREQ), 0);
    chk("ion_off_pil", 32'(bus.PIL), 0);
    bus.ION = 1'b1;
    tick();
    chk("ion_on_req", 32'(bus.LVREQ), 1);
    chk("ion_on_lvl", 32'(bus.NEWLVL), 15);
    ack();
    chk("pil_15", 32'(bus.PIL), 15);
    tick();
    tick();

    // Load-zero, exit and set on the current level, all in one cycle
    pulse_set(16'h0008);
    chk("pid_8008", 32'(bus.PID), 32'h8008);
    bus.WDATA   = 16'h0000;
    bus.LD_PID  = 1'b1;
    bus.LVEXIT  = 1'b1;
    bus.PID_SET = 16'h8000;
    tick();
    clear_inputs();
    bus.ION = 1'b1;
    chk("set_wins", 32'(bus.PID), 32'h8000);

    // Asynchronous reset mid-handshake at PIL=5
    do_reset();
    load_pie(16'hFFFF);
    bus.ION = 1'b1;
    pulse_set(16'h0020);
    tick();
    chk("newlvl_5", 32'(bus.NEWLVL), 5);
    ack();
    tick();
    tick();
    pulse_set(16'h0200);
    tick();
    chk("pre_rst_req", 32'(bus.LVREQ), 1);
    chk("pre_rst_pil", 32'(bus.PIL), 5);
    #2;
    MCL_n = 1'b0;
    #1;
    chk("arst_pil", 32'(bus.PIL), 0);
    chk("arst_lvreq", 32'(bus.LVREQ), 0);
    chk("arst_pid", 32'(bus.PID), 0);
    chk("arst_pie", 32'(bus.PIE), 0);
    chk("arst_newlvl", 32'(bus.NEWLVL), 0);
    tick();
    MCL_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
